// File: rtl/lab2_nibble_serial_cla_adder.sv
// Multi-cycle nibble-serial carry-lookahead adder: one 4-bit CLA slice per clock, LSB nibble first.
// Optional signed-overflow output Ovf is enabled by defining LAB2_OVERFLOW_EN.
module lab2_nibble_serial_cla_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef LAB2_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] shadow;
    logic             carry;
    logic [CW-1:0]    k;

    logic [3:0]       p;
    logic [3:0]       g;
    logic [4:0]       c;
    logic [3:0]       slice_sum;
    logic [WIDTH-1:0] shadow_next;

    // Operands shift right each slice, so the active nibble is always bits [3:0];
    // the result shifts in from the top so nibble 0 lands at the bottom after NIBBLES slices.
    always_comb begin
        p    = x_q[3:0] ^ y_q[3:0];
        g    = x_q[3:0] & y_q[3:0];
        c    = '0;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        slice_sum   = p ^ c[3:0];
        shadow_next = (shadow >> 4) | (WIDTH'(slice_sum) << (WIDTH - 4));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Sum    <= '0;
            Cout   <= 1'b0;
`ifdef LAB2_OVERFLOW_EN
            Ovf    <= 1'b0;
`endif
            x_q    <= '0;
            y_q    <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            k      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_q   <= X;
                        y_q   <= Y;
                        carry <= Cin;
                        k     <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    x_q    <= x_q >> 4;
                    y_q    <= y_q >> 4;
                    shadow <= shadow_next;
                    carry  <= c[4];
                    k      <= k + CW'(1);
                    if (k == K_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Sum   <= shadow_next;
                        Cout  <= c[4];
`ifdef LAB2_OVERFLOW_EN
                        Ovf   <= c[3] ^ c[4];
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
